// File: rtl/clock_divider.sv
// Integer clock divider: registered square wave, low for DIVISOR/2 cycles then high for the rest.
// Define CLKDIV_TICK_OUT_EN to add a one-cycle 'tick' output at each period wrap.
module clock_divider #(
    parameter int unsigned DIVISOR = 5000
) (
    input  logic clk,
    input  logic rst,
    output logic slowerClock
`ifdef CLKDIV_TICK_OUT_EN
    ,
    output logic tick
`endif
);

    // Guarded so an illegal DIVISOR still elaborates far enough to report the error.
    localparam int unsigned CW = (DIVISOR < 2) ? 1 : $clog2(DIVISOR);
    localparam int unsigned L  = DIVISOR / 2;
    localparam int unsigned H  = DIVISOR - L;

    localparam logic [CW-1:0] LAST = CW'(DIVISOR - 1);
    localparam logic [CW-1:0] RISE = CW'(L);

    if (DIVISOR < 2) begin : g_bad_divisor
        $error("clock_divider: DIVISOR must be at least 2");
    end

    if ((H < L) || (H > L + 1)) begin : g_bad_phase
        $error("clock_divider: inconsistent phase lengths");
    end

    logic [CW-1:0] count;
    logic [CW-1:0] count_next;
    logic          wrap;
    logic          slower_next;

    always_comb begin
        wrap        = (count == LAST);
        count_next  = wrap ? '0 : count + CW'(1);
        // Output follows the next count so its edges land on the same clk edge as the count.
        slower_next = (count_next >= RISE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count       <= '0;
            slowerClock <= 1'b0;
        end else begin
            count       <= count_next;
            slowerClock <= slower_next;
        end
    end

`ifdef CLKDIV_TICK_OUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick <= 1'b0;
        end else begin
            tick <= wrap;
        end
    end
`endif

endmodule

// File: tb/tb_clock_divider.sv
// Self-checking bench for clock_divider: DIVISOR 5000 phase/period/reset checks,
// plus table-driven patterns for DIVISOR 2, 3 and 4 (and tick when enabled).
module tb_clock_divider;

    logic clk = 1'b0;
    logic rst_big;
    logic rst_small;
    logic out_big;
    logic out_d2;
    logic out_d3;
    logic out_d4;
`ifdef CLKDIV_TICK_OUT_EN
    logic tick_d4;
`endif

    int checks = 0;
    int errors = 0;

    int   edge_no;
    logic prev_big;
    int   rises[$];
    int   falls[$];

    typedef struct {
        int   k;
        logic d2;
        logic d3;
        logic d4;
        logic tick;
    } vec_t;

    vec_t vecs[12];

    always #10 clk = ~clk;

    clock_divider #(.DIVISOR(5000)) u_big (
        .clk         (clk),
        .rst         (rst_big),
        .slowerClock (out_big)
`ifdef CLKDIV_TICK_OUT_EN
        ,
        .tick        ()
`endif
    );

    clock_divider #(.DIVISOR(2)) u_d2 (
        .clk         (clk),
        .rst         (rst_small),
        .slowerClock (out_d2)
`ifdef CLKDIV_TICK_OUT_EN
        ,
        .tick        ()
`endif
    );

    clock_divider #(.DIVISOR(3)) u_d3 (
        .clk         (clk),
        .rst         (rst_small),
        .slowerClock (out_d3)
`ifdef CLKDIV_TICK_OUT_EN
        ,
        .tick        ()
`endif
    );

    clock_divider #(.DIVISOR(4)) u_d4 (
        .clk         (clk),
        .rst         (rst_small),
        .slowerClock (out_d4)
`ifdef CLKDIV_TICK_OUT_EN
        ,
        .tick        (tick_d4)
`endif
    );

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Advance n edges of the DIVISOR=5000 instance, logging the edge index of every transition.
    task automatic step_big(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            edge_no++;
            if (out_big && !prev_big) rises.push_back(edge_no);
            if (!out_big && prev_big) falls.push_back(edge_no);
            prev_big = out_big;
        end
    endtask

    task automatic check_small(input int i);
        check_bit($sformatf("d2_edge%0d", vecs[i].k), out_d2, vecs[i].d2);
        check_bit($sformatf("d3_edge%0d", vecs[i].k), out_d3, vecs[i].d3);
        check_bit($sformatf("d4_edge%0d", vecs[i].k), out_d4, vecs[i].d4);
`ifdef CLKDIV_TICK_OUT_EN
        check_bit($sformatf("tick_edge%0d", vecs[i].k), tick_d4, vecs[i].tick);
`endif
    endtask

    initial begin
        //            k   d2    d3    d4    tick
        vecs[0]  = '{1,  1'b1, 1'b1, 1'b0, 1'b0};
        vecs[1]  = '{2,  1'b0, 1'b1, 1'b1, 1'b0};
        vecs[2]  = '{3,  1'b1, 1'b0, 1'b1, 1'b0};
        vecs[3]  = '{4,  1'b0, 1'b1, 1'b0, 1'b1};
        vecs[4]  = '{5,  1'b1, 1'b1, 1'b0, 1'b0};
        vecs[5]  = '{6,  1'b0, 1'b0, 1'b1, 1'b0};
        vecs[6]  = '{7,  1'b1, 1'b1, 1'b1, 1'b0};
        vecs[7]  = '{8,  1'b0, 1'b1, 1'b0, 1'b1};
        vecs[8]  = '{9,  1'b1, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{10, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[10] = '{11, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[11] = '{12, 1'b0, 1'b0, 1'b0, 1'b1};

        rst_big   = 1'b1;
        rst_small = 1'b1;
        edge_no   = 0;
        prev_big  = 1'b0;

        // Reset hold, before and after the first clk edge.
        #5;
        check_bit("big_reset_no_edge", out_big, 1'b0);
        check_bit("d4_reset_no_edge", out_d4, 1'b0);
        #6;
        check_bit("big_reset_after_edge", out_big, 1'b0);
        #9;
        rst_big = 1'b0;

        // First period after release.
        step_big(5000);
        check_int("first_period_rise_count", rises.size(), 1);
        check_int("first_rise_edge", (rises.size() > 0) ? rises[0] : -1, 2500);
        check_int("first_fall_edge", (falls.size() > 0) ? falls[0] : -1, 5000);

        // Ten more periods of steady state.
        step_big(50000);
        check_int("steady_rise_count", rises.size(), 11);
        check_int("steady_fall_count", falls.size(), 11);
        for (int n = 1; n <= 10; n++) begin
            check_int($sformatf("period_%0d", n),
                      (rises.size() > n) ? rises[n] - rises[n-1] : -1, 5000);
            check_int($sformatf("high_time_%0d", n),
                      (rises.size() > n && falls.size() > n) ? falls[n] - rises[n] : -1, 2500);
        end

        // Async reset mid-period while the output is high (count 3000).
        step_big(3000);
        check_bit("mid_high_before_reset", out_big, 1'b1);
        #5;
        rst_big = 1'b1;
        #1;
        check_bit("async_reset_drop", out_big, 1'b0);
        @(posedge clk);
        #1;
        check_bit("reset_held_over_edge", out_big, 1'b0);
        #5;
        rst_big = 1'b0;
        rises.delete();
        falls.delete();
        edge_no  = 0;
        prev_big = 1'b0;
        step_big(2600);
        check_int("post_reset_rise_count", rises.size(), 1);
        check_int("post_reset_first_rise", (rises.size() > 0) ? rises[0] : -1, 2500);

        // Small ratios: still in reset after many edges.
        check_bit("d2_in_reset", out_d2, 1'b0);
        check_bit("d3_in_reset", out_d3, 1'b0);
        check_bit("d4_in_reset", out_d4, 1'b0);
`ifdef CLKDIV_TICK_OUT_EN
        check_bit("tick_in_reset", tick_d4, 1'b0);
`endif
        #5;
        rst_small = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            check_small(i);
        end

        // Two more edges: edge 14 has d4 and d3 high, then reset asynchronously.
        @(posedge clk);
        @(posedge clk);
        #1;
        check_bit("d4_edge14_high", out_d4, 1'b1);
        check_bit("d3_edge14_high", out_d3, 1'b1);
        #5;
        rst_small = 1'b1;
        #1;
        check_bit("d3_async_drop", out_d3, 1'b0);
        check_bit("d4_async_drop", out_d4, 1'b0);
`ifdef CLKDIV_TICK_OUT_EN
        check_bit("tick_async_reset", tick_d4, 1'b0);
`endif
        #5;
        rst_small = 1'b0;
        // Phase restarts from edge 1 after release.
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            check_small(i);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
